// File: rtl/match_pkg.sv
// Shared types and constants for the best-of-N match scoreboard.
package match_pkg;

    typedef enum logic [2:0] {
        ARMED    = 3'd0,
        SCORE    = 3'd1,
        NEXT     = 3'd2,
        WAIT_LOW = 3'd3,
        REPORT   = 3'd4
    } state_e;

    localparam logic [1:0] WHO_WIN  = 2'b10;
    localparam logic [1:0] WHO_LOSE = 2'b01;
    localparam logic [1:0] WHO_NONE = 2'b00;

    // Games needed to take a best-of-rounds series.
    function automatic int unsigned majority(input int unsigned rounds);
        return rounds / 2 + 1;
    endfunction

    function automatic logic who_legal(input logic [1:0] who);
        return (who == WHO_WIN) || (who == WHO_LOSE);
    endfunction

endpackage

// File: rtl/rise_detect.sv
// Rising-edge detector; the delay register resets high so a level already
// present when reset is released does not produce a pulse.
module rise_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic level,
    output logic pulse
);

    logic level_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_d <= 1'b1;
        end else begin
            level_d <= level;
        end
    end

    assign pulse = level & ~level_d;

endmodule

// File: rtl/match_scoreboard.sv
// Best-of-ROUNDS series scoreboard: counts game results from an upstream game
// counter, reports the series winner over valid/ready and flags protocol abuse.
module match_scoreboard
    import match_pkg::*;
#(
    parameter  int unsigned ROUNDS = 5,
    localparam int unsigned TW     = $clog2(ROUNDS + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          gameover,
    input  logic [1:0]    who,
    input  logic          clear,
    input  logic          result_ready,
    output logic [TW-1:0] win_tally,
    output logic [TW-1:0] lose_tally,
    output logic [TW-1:0] round_num,
    output logic          round_done,
    output logic          next_round,
    output logic          match_valid,
    output logic [1:0]    match_winner,
    output logic          protocol_err,
    output logic          overrun
);

    localparam int unsigned   MAJ      = majority(ROUNDS);
    localparam logic [TW-1:0] MAJ_T    = TW'(MAJ);
    localparam logic [TW-1:0] ROUNDS_T = TW'(ROUNDS);

    state_e        state_q, state_d;
    logic [TW-1:0] win_q, win_d;
    logic [TW-1:0] lose_q, lose_d;
    logic [TW-1:0] round_q, round_d;
    logic [1:0]    who_q, who_d;
    logic          round_done_q, round_done_d;
    logic          perr_q, perr_d;
    logic          ovr_q, ovr_d;

    logic          game_evt;
    logic [TW-1:0] win_inc;
    logic [TW-1:0] lose_inc;
    logic [TW-1:0] round_inc;

    rise_detect u_rise_detect (
        .clk   (clk),
        .rst_n (rst_n),
        .level (gameover),
        .pulse (game_evt)
    );

    // Saturating increments keep the tallies from ever passing MAJ.
    assign win_inc   = (win_q < MAJ_T) ? win_q + 1'b1 : win_q;
    assign lose_inc  = (lose_q < MAJ_T) ? lose_q + 1'b1 : lose_q;
    assign round_inc = (round_q < ROUNDS_T) ? round_q + 1'b1 : round_q;

    always_comb begin
        state_d      = state_q;
        win_d        = win_q;
        lose_d       = lose_q;
        round_d      = round_q;
        who_d        = who_q;
        round_done_d = 1'b0;
        perr_d       = perr_q;
        ovr_d        = ovr_q;

        if (clear) begin
            state_d = ARMED;
            win_d   = '0;
            lose_d  = '0;
            round_d = '0;
            who_d   = WHO_NONE;
            perr_d  = 1'b0;
            ovr_d   = 1'b0;
        end else begin
            unique case (state_q)
                ARMED: begin
                    if (game_evt) begin
                        if (who_legal(who)) begin
                            who_d   = who;
                            state_d = SCORE;
                        end else begin
                            perr_d  = 1'b1;
                            state_d = WAIT_LOW;
                        end
                    end
                end
                SCORE: begin
                    round_done_d = 1'b1;
                    round_d      = round_inc;
                    if (game_evt) begin
                        ovr_d = 1'b1;
                    end
                    if (who_q == WHO_WIN) begin
                        win_d   = win_inc;
                        state_d = (win_inc == MAJ_T) ? REPORT : NEXT;
                    end else begin
                        lose_d  = lose_inc;
                        state_d = (lose_inc == MAJ_T) ? REPORT : NEXT;
                    end
                end
                NEXT: begin
                    if (game_evt) begin
                        ovr_d = 1'b1;
                    end
                    state_d = WAIT_LOW;
                end
                WAIT_LOW: begin
                    if (!gameover) begin
                        state_d = ARMED;
                    end
                end
                REPORT: begin
                    if (game_evt) begin
                        ovr_d = 1'b1;
                    end
                    if (result_ready) begin
                        win_d   = '0;
                        lose_d  = '0;
                        round_d = '0;
                        state_d = WAIT_LOW;
                    end
                end
                default: begin
                    state_d = ARMED;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ARMED;
            win_q        <= '0;
            lose_q       <= '0;
            round_q      <= '0;
            who_q        <= WHO_NONE;
            round_done_q <= 1'b0;
            perr_q       <= 1'b0;
            ovr_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            win_q        <= win_d;
            lose_q       <= lose_d;
            round_q      <= round_d;
            who_q        <= who_d;
            round_done_q <= round_done_d;
            perr_q       <= perr_d;
            ovr_q        <= ovr_d;
        end
    end

    assign win_tally    = win_q;
    assign lose_tally   = lose_q;
    assign round_num    = round_q;
    assign round_done   = round_done_q;
    assign next_round   = (state_q == NEXT);
    assign match_valid  = (state_q == REPORT);
    assign match_winner = !match_valid   ? WHO_NONE :
                          (win_q == MAJ_T) ? WHO_WIN : WHO_LOSE;
    assign protocol_err = perr_q;
    assign overrun      = ovr_q;

endmodule

// File: tb/tb_match_scoreboard.sv
// Randomised self-checking bench for match_scoreboard against a game-level model.
module tb_match_scoreboard;
    import match_pkg::*;

    localparam int unsigned ROUNDS = 5;
    localparam int unsigned TW     = 3;
    localparam int unsigned MAJ    = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          gameover = 1'b0;
    logic [1:0]    who = 2'b00;
    logic          clear = 1'b0;
    logic          result_ready = 1'b0;
    logic [TW-1:0] win_tally, lose_tally, round_num;
    logic          round_done, next_round, match_valid;
    logic [1:0]    match_winner;
    logic          protocol_err, overrun;

    int n_vec = 0;
    int n_err = 0;
    int rd_seen = 0;
    int nr_seen = 0;

    // Reference model: series score and sticky flags, updated once per game.
    int m_win = 0, m_lose = 0, m_round = 0, m_rd = 0, m_nr = 0;
    bit m_valid = 0, m_perr = 0, m_ovr = 0;

    match_scoreboard #(.ROUNDS(ROUNDS)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .gameover     (gameover),
        .who          (who),
        .clear        (clear),
        .result_ready (result_ready),
        .win_tally    (win_tally),
        .lose_tally   (lose_tally),
        .round_num    (round_num),
        .round_done   (round_done),
        .next_round   (next_round),
        .match_valid  (match_valid),
        .match_winner (match_winner),
        .protocol_err (protocol_err),
        .overrun      (overrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (round_done) rd_seen++;
        if (next_round) nr_seen++;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int exp_winner();
        if (!m_valid) return 0;
        return (m_win == MAJ) ? 2 : 1;
    endfunction

    task automatic check_all(input string tag);
        check_eq({tag, ".win"},    32'(win_tally),    32'(m_win));
        check_eq({tag, ".lose"},   32'(lose_tally),   32'(m_lose));
        check_eq({tag, ".round"},  32'(round_num),    32'(m_round));
        check_eq({tag, ".valid"},  32'(match_valid),  32'(m_valid));
        check_eq({tag, ".winner"}, 32'(match_winner), 32'(exp_winner()));
        check_eq({tag, ".perr"},   32'(protocol_err), 32'(m_perr));
        check_eq({tag, ".ovr"},    32'(overrun),      32'(m_ovr));
        check_eq({tag, ".rd_cnt"}, 32'(rd_seen),      32'(m_rd));
        check_eq({tag, ".nr_cnt"}, 32'(nr_seen),      32'(m_nr));
    endtask

    task automatic model_reset();
        m_win = 0; m_lose = 0; m_round = 0;
        m_valid = 0; m_perr = 0; m_ovr = 0;
    endtask

    task automatic play_game(input string tag, input logic [1:0] w, input int hold);
        bit legal;
        bit counted;
        legal   = (w == WHO_WIN) || (w == WHO_LOSE);
        counted = legal && !m_valid;
        if (m_valid) begin
            m_ovr = 1;
        end else if (!legal) begin
            m_perr = 1;
        end else begin
            if (w == WHO_WIN) m_win++; else m_lose++;
            m_round++;
            m_rd++;
            if (m_win == MAJ || m_lose == MAJ) m_valid = 1; else m_nr++;
        end
        @(posedge clk); #1;
        gameover = 1'b1;
        who      = w;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            if (c == hold - 1) gameover = 1'b0;
            if (c == 1 && counted) begin
                check_eq({tag, ".lat_win"},   32'(win_tally),   32'(m_win));
                check_eq({tag, ".lat_lose"},  32'(lose_tally),  32'(m_lose));
                check_eq({tag, ".lat_rdone"}, 32'(round_done),  32'd1);
                check_eq({tag, ".lat_valid"}, 32'(match_valid), 32'(m_valid));
            end
            if (c >= hold - 1 && c >= 1) break;
        end
        repeat (4) @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic accept(input string tag);
        check_eq({tag, ".pre_valid"},  32'(match_valid),  32'(m_valid));
        check_eq({tag, ".pre_winner"}, 32'(match_winner), 32'(exp_winner()));
        result_ready = 1'b1;
        @(posedge clk); #1;
        result_ready = 1'b0;
        m_win = 0; m_lose = 0; m_round = 0; m_valid = 0;
        check_eq({tag, ".post_win"},   32'(win_tally),   32'(m_win));
        check_eq({tag, ".post_lose"},  32'(lose_tally),  32'(m_lose));
        check_eq({tag, ".post_round"}, 32'(round_num),   32'(m_round));
        check_eq({tag, ".post_valid"}, 32'(match_valid), 32'(m_valid));
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic do_clear(input string tag);
        @(posedge clk); #1;
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        model_reset();
        check_all(tag);
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        check_all(tag);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        int          r;
        int          nr0;
        logic [1:0]  w;

        // Reset with gameover already high: must not count once released.
        gameover = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_all("reset");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check_all("go_high_at_release");
        gameover = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // Three straight wins, result held until accepted.
        play_game("w1", WHO_WIN, 2);
        play_game("w2", WHO_WIN, 1);
        play_game("w3", WHO_WIN, 3);
        repeat (5) @(posedge clk);
        #1;
        check_all("held");
        accept("acc_www");

        // W L L W L series.
        nr0 = nr_seen;
        play_game("s1", WHO_WIN, 2);
        play_game("s2", WHO_LOSE, 2);
        play_game("s3", WHO_LOSE, 1);
        play_game("s4", WHO_WIN, 4);
        play_game("s5", WHO_LOSE, 2);
        check_eq("wllwl.next_rounds", 32'(nr_seen - nr0), 32'd4);
        accept("acc_wllwl");

        // Illegal result code, then a long-held level.
        play_game("pre_ill", WHO_WIN, 2);
        play_game("ill00", 2'b00, 2);
        play_game("hold6", WHO_WIN, 6);
        // Third win decides; a further game while unaccepted is an overrun.
        play_game("decide", WHO_LOSE, 2);
        play_game("win3", WHO_WIN, 2);
        play_game("overrun", WHO_LOSE, 3);
        accept("acc_ovr");
        do_clear("clr_flags");

        // Reset mid-series, then clear mid-series.
        play_game("r1", WHO_WIN, 2);
        play_game("r2", WHO_WIN, 2);
        do_reset("rst_mid");
        play_game("after_rst", WHO_WIN, 2);
        play_game("c1", WHO_WIN, 1);
        do_clear("clr_mid");
        play_game("after_clr", WHO_LOSE, 2);

        for (int i = 0; i < 60; i++) begin
            r = $urandom_range(0, 15);
            if (m_valid && r < 8) begin
                accept("rnd_acc");
            end else if (r == 15) begin
                do_clear("rnd_clr");
            end else begin
                if ($urandom_range(0, 7) == 0) begin
                    w = ($urandom_range(0, 1) == 1) ? 2'b11 : 2'b00;
                end else begin
                    w = ($urandom_range(0, 1) == 1) ? WHO_WIN : WHO_LOSE;
                end
                play_game("rnd_game", w, int'($urandom_range(1, 6)));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
